// File: rtl/lock_pkg.sv
// Shared definitions for the keypad entry path: key codes, lock-state encodings,
// buffer depth and the factory password.
package lock_pkg;

    localparam int unsigned MAX_DIGITS     = 8;
    localparam logic [31:0] DEFAULT_PW     = 32'h0000_0000;
    localparam logic [3:0]  DEFAULT_PW_LEN = 4'd4;
    localparam logic [3:0]  MIN_NEW_PW_LEN = 4'd4;

    localparam logic [3:0] KEY_STAR  = 4'hA;
    localparam logic [3:0] KEY_HASH  = 4'hB;
    localparam logic [3:0] KEY_RESET = 4'hC;
    localparam logic [3:0] KEY_INIT  = 4'hD;

    typedef enum logic [2:0] {
        LS_OFF    = 3'b000,
        LS_ON     = 3'b001,
        LS_WRONG1 = 3'b010,
        LS_WRONG2 = 3'b011,
        LS_ANSWER = 3'b100,
        LS_RESET  = 3'b101,
        LS_LOCK   = 3'b111
    } lock_state_e;

    // Busy sequence after an accepted '*': pulse cycle, then clear cycle.
    typedef enum logic [1:0] {
        PH_IDLE,
        PH_PULSE,
        PH_CLEAR
    } phase_e;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

    // States in which digits are buffered and '*' starts a check/commit.
    function automatic logic takes_entry(input logic [2:0] st);
        return (st == LS_ON) || (st == LS_WRONG1) || (st == LS_WRONG2) || (st == LS_RESET);
    endfunction

endpackage

// File: rtl/entry_buffer.sv
// BCD entry shift register with digit counter; newest digit in the low nibble,
// saturates at MAX_DIGITS, clear has priority over shift.
module entry_buffer
    import lock_pkg::*;
#(
    parameter int unsigned MAX_DIGITS = lock_pkg::MAX_DIGITS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      shift_en,
    input  logic                      clear,
    input  logic [3:0]                digit,
    output logic [4*MAX_DIGITS-1:0]   data,
    output logic [3:0]                count
);

    logic [4*MAX_DIGITS-1:0] data_q, data_d;
    logic [3:0]              count_q, count_d;

    always_comb begin
        data_d  = data_q;
        count_d = count_q;
        if (clear) begin
            data_d  = '0;
            count_d = '0;
        end else if (shift_en && (count_q < 4'(MAX_DIGITS))) begin
            data_d  = {data_q[4*MAX_DIGITS-5:0], digit};
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign data  = data_q;
    assign count = count_q;

endmodule

// File: rtl/keypad_entry.sv
// Keypad front end for the lock: buffers digits, checks/commits passwords on '*',
// and produces the on/off level plus star, reset and initialize pulses.
module keypad_entry
    import lock_pkg::*;
#(
    parameter int unsigned MAX_DIGITS = lock_pkg::MAX_DIGITS,
    parameter logic [31:0] DEFAULT_PW = lock_pkg::DEFAULT_PW
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic [2:0] state,
    output logic       is_on,
    output logic       is_star_pressed,
    output logic       reset,
    output logic       correct,
    output logic       initialize,
    output logic [3:0] digit_count
);

    localparam int unsigned BUF_W = 4 * MAX_DIGITS;

    phase_e             phase_q, phase_d;
    logic               is_on_q, is_on_d;
    logic               star_q, star_d;
    logic               reset_q, reset_d;
    logic               init_q, init_d;
    logic [BUF_W-1:0]   pw_q, pw_d;
    logic [3:0]         pw_len_q, pw_len_d;

    logic               buf_shift;
    logic               buf_clear;
    logic [BUF_W-1:0]   buf_data;
    logic [3:0]         buf_count;

    entry_buffer #(
        .MAX_DIGITS(MAX_DIGITS)
    ) u_entry_buffer (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (buf_shift),
        .clear    (buf_clear),
        .digit    (key_code),
        .data     (buf_data),
        .count    (buf_count)
    );

    always_comb begin
        phase_d   = phase_q;
        is_on_d   = is_on_q;
        star_d    = 1'b0;
        reset_d   = 1'b0;
        init_d    = 1'b0;
        pw_d      = pw_q;
        pw_len_d  = pw_len_q;
        buf_shift = 1'b0;
        buf_clear = 1'b0;

        // D is honoured even mid-sequence and wins over any pending commit.
        if (key_valid && (key_code == KEY_INIT)) begin
            init_d    = 1'b1;
            is_on_d   = 1'b0;
            buf_clear = 1'b1;
            phase_d   = PH_IDLE;
            pw_d      = BUF_W'(DEFAULT_PW);
            pw_len_d  = DEFAULT_PW_LEN;
        end else begin
            case (phase_q)
                PH_PULSE: begin
                    phase_d = PH_CLEAR;
                    if ((state == LS_RESET) && (buf_count >= MIN_NEW_PW_LEN)) begin
                        pw_d     = buf_data;
                        pw_len_d = buf_count;
                        is_on_d  = 1'b0;
                    end
                end
                PH_CLEAR: begin
                    phase_d   = PH_IDLE;
                    buf_clear = 1'b1;
                end
                default: begin
                    if (key_valid && (state != LS_LOCK)) begin
                        if (is_digit(key_code)) begin
                            buf_shift = takes_entry(state);
                        end else if (key_code == KEY_STAR) begin
                            if (takes_entry(state)) begin
                                phase_d = PH_PULSE;
                                star_d  = 1'b1;
                            end
                        end else if (key_code == KEY_HASH) begin
                            is_on_d   = ~is_on_q;
                            buf_clear = 1'b1;
                        end else if ((key_code == KEY_RESET) && (state == LS_ANSWER)) begin
                            reset_d   = 1'b1;
                            buf_clear = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= PH_IDLE;
            is_on_q  <= 1'b0;
            star_q   <= 1'b0;
            reset_q  <= 1'b0;
            init_q   <= 1'b0;
            pw_q     <= BUF_W'(DEFAULT_PW);
            pw_len_q <= DEFAULT_PW_LEN;
        end else begin
            phase_q  <= phase_d;
            is_on_q  <= is_on_d;
            star_q   <= star_d;
            reset_q  <= reset_d;
            init_q   <= init_d;
            pw_q     <= pw_d;
            pw_len_q <= pw_len_d;
        end
    end

    always_comb begin
        correct = 1'b0;
        case (state)
            LS_ON, LS_WRONG1, LS_WRONG2: correct = (buf_count == pw_len_q) && (buf_data == pw_q);
            LS_RESET:                    correct = (buf_count >= MIN_NEW_PW_LEN);
            default:                     correct = 1'b0;
        endcase
    end

    assign is_on           = is_on_q;
    assign is_star_pressed = star_q;
    assign reset           = reset_q;
    assign initialize      = init_q;
    assign digit_count     = buf_count;

endmodule
